// File: rtl/restoring_divide_fsmd_pkg.sv
// Shared arithmetic package: default operand width and the divider FSM state encoding.
package restoring_divide_fsmd_pkg;

  localparam int DATA_SIZE_DEF = 8;

  typedef enum logic [1:0] {
    START    = 2'b00,
    DIVIDE   = 2'b01,
    SIGN_FIX = 2'b10,
    FINISH   = 2'b11
  } div_state_e;

endpackage

// File: rtl/restoring_divide_fsmd_twos_abs.sv
// Two's-complement magnitude and sign; the most negative value maps to 2^(W-1) unsigned.
module twos_abs #(
  parameter int W = 8
) (
  input  logic [W-1:0] val_i,
  output logic [W-1:0] mag_o,
  output logic         neg_o
);

  assign neg_o = val_i[W-1];
  assign mag_o = neg_o ? (-val_i) : val_i;

endmodule

// File: rtl/restoring_divide_fsmd.sv
// Signed restoring divider: magnitudes divided one quotient bit per cycle, signs fixed at the end.
// state    | meaning
// START    | idle, waits for enable_i to capture operands
// DIVIDE   | one shift/trial-subtract step per cycle, DATA_SIZE steps
// SIGN_FIX | apply result signs, load output registers
// FINISH   | data_valid_o high, waits for enable_i to return to START
module restoring_divide_fsmd
  import restoring_divide_fsmd_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic [DATA_SIZE-1:0] dividend_i,
  input  logic [DATA_SIZE-1:0] divisor_i,
  output logic                 data_valid_o,
  output logic [DATA_SIZE-1:0] quotient_o,
  output logic [DATA_SIZE-1:0] remainder_o,
  output logic                 div_by_zero_o,
  output logic                 overflow_o
);

  localparam int CW = $clog2(DATA_SIZE) + 1;
  localparam logic [DATA_SIZE-1:0] MIN_VAL = {1'b1, {(DATA_SIZE-1){1'b0}}};

  div_state_e           state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DATA_SIZE:0]   rem_q, rem_d;
  logic [DATA_SIZE-1:0] quo_q, quo_d, dvs_q, dvs_d;
  logic                 qneg_q, qneg_d, rneg_q, rneg_d, ovf_q, ovf_d;
  logic [DATA_SIZE-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic                 dbz_q, dbz_d, ovf_out_q, ovf_out_d;

  logic [DATA_SIZE-1:0] dnd_mag, dvs_mag;
  logic                 dnd_neg, dvs_neg;
  logic [DATA_SIZE+1:0] rem_sh, trial;

  twos_abs #(.W(DATA_SIZE)) u_abs_dnd (.val_i(dividend_i), .mag_o(dnd_mag), .neg_o(dnd_neg));
  twos_abs #(.W(DATA_SIZE)) u_abs_dvs (.val_i(divisor_i),  .mag_o(dvs_mag), .neg_o(dvs_neg));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= START;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      ovf_q       <= ovf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_out_q   <= ovf_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    ovf_d       = ovf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_out_d   = ovf_out_q;
    // Partial remainder never exceeds the divisor magnitude, so the trial MSB is a true sign.
    rem_sh      = {rem_q, quo_q[DATA_SIZE-1]};
    trial       = rem_sh - {2'b00, dvs_q};

    case (state_q)
      START: begin
        if (enable_i) begin
          if (divisor_i == '0) begin
            quotient_d  = '1;
            remainder_d = dividend_i;
            dbz_d       = 1'b1;
            ovf_out_d   = 1'b0;
            state_d     = FINISH;
          end else begin
            rem_d   = '0;
            quo_d   = dnd_mag;
            dvs_d   = dvs_mag;
            qneg_d  = dnd_neg ^ dvs_neg;
            rneg_d  = dnd_neg;
            ovf_d   = (dividend_i == MIN_VAL) && (divisor_i == '1);
            count_d = CW'(DATA_SIZE);
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        if (!trial[DATA_SIZE+1]) begin
          rem_d = trial[DATA_SIZE:0];
          quo_d = {quo_q[DATA_SIZE-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[DATA_SIZE:0];
          quo_d = {quo_q[DATA_SIZE-2:0], 1'b0};
        end
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = SIGN_FIX;
      end
      SIGN_FIX: begin
        quotient_d  = qneg_q ? (-quo_q) : quo_q;
        remainder_d = rneg_q ? (-rem_q[DATA_SIZE-1:0]) : rem_q[DATA_SIZE-1:0];
        dbz_d       = 1'b0;
        ovf_out_d   = ovf_q;
        state_d     = FINISH;
      end
      FINISH: begin
        if (enable_i) state_d = START;
      end
      default: state_d = START;
    endcase
  end

  assign data_valid_o  = (state_q == FINISH);
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_q;
  assign overflow_o    = ovf_out_q;

endmodule
